load_store_unit: RTL

//  Memory-access stage between EXEC and WRITE_BACK of the multi-cycle core.
//  - Forms effective address base + sext(imm) and drives the data Bram (whole-word, no byte enables).
//  - Executes LB/LH/LW/LBU/LHU/SB/SH/SW; SB/SH use read-modify-write.
//  - Returns load data and rd to write-back with a one-cycle response pulse.

---
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request, response and data-Bram signals of the load/store unit.
// The slave modport is the unit; the master modport is the core plus Bram side.
interface load_store_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        is_load_i;
  logic        is_store_i;
  logic [2:0]  funct_i;
  logic [31:0] base_i;
  logic [11:0] imm_i;
  logic [31:0] store_data_i;
  logic [4:0]  rd_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        resp_valid_o;
  logic        resp_we_o;
  logic [4:0]  resp_rd_o;
  logic [31:0] resp_data_o;
  logic        misaligned_o;

  modport slave (
    input  req_valid_i, is_load_i, is_store_i, funct_i, base_i, imm_i, store_data_i, rd_i,
           mem_rdata_i,
    output req_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, resp_valid_o, resp_we_o, resp_rd_o,
           resp_data_o, misaligned_o
  );

  modport master (
    output req_valid_i, is_load_i, is_store_i, funct_i, base_i, imm_i, store_data_i, rd_i,
           mem_rdata_i,
    input  req_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, resp_valid_o, resp_we_o, resp_rd_o,
           resp_data_o, misaligned_o
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: effective address, whole-word Bram access with read-modify-write for
// sub-word stores, load extraction and a one-cycle response pulse to write-back.
module load_store_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  localparam logic [2:0] LastCnt = 3'(MEM_LATENCY);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  funct_q, funct_d;
  logic [4:0]  rd_q, rd_d;
  logic        load_q, load_d;
  logic        err_q, err_d;

  logic [31:0] ea;
  logic        legal, misal, req_err;
  logic [31:0] merged, ld_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        resp, good_load;

  assign ea = bus.base_i + {{20{bus.imm_i[11]}}, bus.imm_i};

  always_comb begin
    legal = 1'b0;
    unique case (bus.funct_i)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = bus.is_load_i;
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    misal = 1'b0;
    unique case (bus.funct_i[1:0])
      2'b01:   misal = ea[0];
      2'b10:   misal = (ea[1:0] != 2'b00);
      default: misal = 1'b0;
    endcase
  end

  assign req_err = (bus.is_load_i == bus.is_store_i) | ~legal | misal;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ea_d    = ea_q;
    sdata_d = sdata_q;
    rdata_d = rdata_q;
    funct_d = funct_q;
    rd_d    = rd_q;
    load_d  = load_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid_i) begin
          ea_d    = ea;
          sdata_d = bus.store_data_i;
          funct_d = bus.funct_i;
          rd_d    = bus.rd_i;
          load_d  = bus.is_load_i;
          err_d   = req_err;
          cnt_d   = 3'd0;
          if (req_err) begin
            state_d = StResp;
          end else if (bus.is_store_i && bus.funct_i == 3'b010) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        // Read data is sampled on the (MEM_LATENCY+1)-th edge spent in this state.
        if (cnt_q == LastCnt) begin
          rdata_d = bus.mem_rdata_i;
          state_d = load_q ? StResp : StWrite;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      ea_q    <= 32'd0;
      sdata_q <= 32'd0;
      rdata_q <= 32'd0;
      funct_q <= 3'd0;
      rd_q    <= 5'd0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ea_q    <= ea_d;
      sdata_q <= sdata_d;
      rdata_q <= rdata_d;
      funct_q <= funct_d;
      rd_q    <= rd_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    merged = rdata_q;
    unique case (funct_q[1:0])
      2'b00:   merged[{ea_q[1:0], 3'b000} +: 8] = sdata_q[7:0];
      2'b01:   merged[{ea_q[1], 4'b0000} +: 16] = sdata_q[15:0];
      default: merged = sdata_q;
    endcase
  end

  assign lane_b = rdata_q[{ea_q[1:0], 3'b000} +: 8];
  assign lane_h = rdata_q[{ea_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = rdata_q;
    unique case (funct_q)
      3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_data = {24'd0, lane_b};
      3'b101:  ld_data = {16'd0, lane_h};
      default: ld_data = rdata_q;
    endcase
  end

  assign resp      = (state_q == StResp);
  assign good_load = load_q & ~err_q;

  // All outputs come from registers or state only, so mem_we_o drops with an async reset.
  assign bus.req_ready_o  = (state_q == StIdle);
  assign bus.mem_we_o     = (state_q == StWrite);
  assign bus.mem_addr_o   = {ea_q[31:2], 2'b00};
  assign bus.mem_wdata_o  = (state_q == StWrite) ? merged : 32'd0;
  assign bus.resp_valid_o = resp;
  assign bus.resp_we_o    = resp & good_load & (rd_q != 5'd0);
  assign bus.resp_rd_o    = resp ? rd_q : 5'd0;
  assign bus.resp_data_o  = (resp & good_load) ? ld_data : 32'd0;
  assign bus.misaligned_o = resp & err_q;

endmodule
